md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit (MDU). Accepts MD-class instructions from the execute stage and launches them into the MDU with a one-cycle start pulse and registered operands. Tracks MDU busy, stalls the pipeline while a new MD op cannot be accepted, and returns mfhi/mflo read data. A watchdog flags an MDU that never drops busy.

## Interface
Parameters:
- MAX_WAIT, 16, cycles allowed in WAIT before `md_timeout` asserts (range 2..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- req_valid  in  1  an MD-class op is presented this cycle
- req_op  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 msub, 6 mthi, 7 mtlo, 8 mfhi, 9 mflo; 10-15 reserved
- req_rs  in  32  rs operand
- req_rt  in  32  rt operand
- flush  in  1  suppresses acceptance this cycle; does not abort ops already launched
- req_ready  out  1  op accepted this cycle (combinational)
- stall  out  1  = req_valid & ~req_ready & ~flush
- md_start  out  1  one-cycle launch pulse to MDU (registered)
- md_op  out  3  req_op[2:0] of launched op (registered)
- md_a  out  32  launched rs (registered)
- md_b  out  32  launched rt (registered)
- md_busy  in  1  MDU busy; may rise in the same cycle as md_start
- md_hi  in  32  MDU HI register
- md_lo  in  32  MDU LO register
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  32  mfhi/mflo result (registered, held until next read)
- md_timeout  out  1  sticky watchdog flag, cleared only by reset

## Operation
- States: IDLE, LAUNCH, WAIT.
- Acceptance: req_ready = req_valid & ~flush & state==IDLE & ~md_busy & req_op<=9. Reserved opcodes never accepted (stall held).
- Long ops (0-5) accepted in IDLE: capture rs/rt/op into md_a/md_b/md_op, md_start=1 next cycle, state -> LAUNCH -> WAIT.
- mthi/mtlo (6,7): launched identically; LAUNCH -> IDLE (no WAIT).
- mfhi/mflo (8,9): no md_start; next cycle rd_data = md_hi or md_lo sampled at acceptance edge, rd_valid=1 for one cycle; state stays IDLE.
- WAIT: exits to IDLE in the cycle after md_busy is sampled 0; minimum one WAIT cycle regardless of md_busy.
- Watchdog: 8-bit counter cleared on entering WAIT, increments each WAIT cycle, saturates at 255; when count reaches MAX_WAIT, md_timeout sets (sticky). State machine continues waiting.
- flush: blocks acceptance only; LAUNCH/WAIT progress unaffected; stall forced 0 while flush=1.
- md_a/md_b/md_op hold last launched values between launches.

## Timing
- Reset (async, immediate): state IDLE; md_start 0, md_op 0, md_a 0, md_b 0, rd_valid 0, rd_data 0, md_timeout 0, watchdog 0. req_ready/stall follow combinationally from IDLE.
- Reset mid-LAUNCH/WAIT: md_start drops immediately; MDU state is not this block's concern.
- Launch latency: accept at edge N -> md_start high cycle N+1 -> WAIT from N+2.
- Back-to-back long ops: earliest second acceptance is the cycle after WAIT exits to IDLE, given md_busy=0.
- mfhi/mflo latency: 1 cycle; back-to-back reads accepted every cycle (rd_valid stays high).
- mfhi while WAIT or md_busy=1: stalled until IDLE & ~md_busy.
- Simultaneous req_valid and flush: not accepted, stall=0, no state change.

## Test plan
- Reset then mult rs=0x0000_0003, rt=0xFFFF_FFFE, MDU busy 5 cycles -> md_start 1 cycle with md_op=0, md_a=3, md_b=0xFFFF_FFFE; stall=1 on any request during LAUNCH/WAIT; IDLE 1 cycle after busy falls.
- mthi rs=0x1234_5678 from IDLE, md_busy=0 -> md_start pulse, md_op=6; next op accepted 2 cycles after acceptance.
- mflo with md_lo=0xDEAD_BEEF, md_busy=0 -> rd_valid=1, rd_data=0xDEAD_BEEF one cycle later; no md_start.
- div followed immediately by mfhi -> mfhi stalled through LAUNCH/WAIT; accepted when busy=0, rd_data = md_hi at that time.
- MDU holds busy=1 for 40 cycles, MAX_WAIT=16 -> md_timeout sets after 16 WAIT cycles, stays 1 after busy falls until reset.
- Assert reset during WAIT, and req_valid+flush together in IDLE -> all outputs zero immediately / no acceptance, stall=0, state unchanged.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - MD-class instruction issue controller for the multiply/divide unit
module md_issue_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        md_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  state_t     state, state_nx;
  logic [7:0] wd_cnt, wd_inc;
  logic       is_read;
  logic       launch;

  always_comb begin
    is_read   = (req_op == 4'd8) || (req_op == 4'd9);
    req_ready = req_valid & ~flush & (state == IDLE) & ~md_busy & (req_op <= 4'd9);
    stall     = req_valid & ~req_ready & ~flush;
    launch    = req_ready & ~is_read;
    wd_inc    = (wd_cnt == 8'hFF) ? 8'hFF : wd_cnt + 8'd1;
  end

  // mthi/mtlo (md_op 6,7) complete in LAUNCH; everything else waits on md_busy
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = LAUNCH;
      LAUNCH:  state_nx = (md_op >= 3'd6) ? IDLE : WAIT;
      WAIT:    if (!md_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      md_start   <= 1'b0;
      md_op      <= 3'd0;
      md_a       <= 32'd0;
      md_b       <= 32'd0;
      rd_valid   <= 1'b0;
      rd_data    <= 32'd0;
      md_timeout <= 1'b0;
      wd_cnt     <= 8'd0;
    end else begin
      state    <= state_nx;
      md_start <= launch;
      rd_valid <= req_ready & is_read;
      if (launch) begin
        md_op <= req_op[2:0];
        md_a  <= req_rs;
        md_b  <= req_rt;
      end
      if (req_ready && is_read)
        rd_data <= req_op[0] ? md_lo : md_hi;
      if (state == LAUNCH && state_nx == WAIT) begin
        wd_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_inc;
        if (wd_inc == MAX_WAIT_W)
          md_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - directed self-checking bench for md_issue_ctrl
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_rs = 32'd0;
  logic [31:0] req_rt = 32'd0;
  logic        flush = 1'b0;
  logic        req_ready, stall, md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_busy = 1'b0;
  logic [31:0] md_hi = 32'd0;
  logic [31:0] md_lo = 32'd0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        md_timeout;

  int n_cmp = 0;
  int n_err = 0;

  md_issue_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .flush(flush), .req_ready(req_ready), .stall(stall),
    .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .rd_valid(rd_valid), .rd_data(rd_data), .md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    req_valid = v;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_md_start", 32'(md_start), 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_timeout", 32'(md_timeout), 32'd0);
    reset = 1'b0;
    tick();

    // mult, MDU busy 5 cycles
    req(1'b1, 4'd0, 32'h0000_0003, 32'hFFFF_FFFE);
    chk("mult_ready", 32'(req_ready), 32'd1);
    chk("mult_stall", 32'(stall), 32'd0);
    tick();
    md_busy = 1'b1;
    #1;
    chk("mult_start", 32'(md_start), 32'd1);
    chk("mult_op", 32'(md_op), 32'd0);
    chk("mult_a", md_a, 32'h0000_0003);
    chk("mult_b", md_b, 32'hFFFF_FFFE);
    chk("launch_stall", 32'(stall), 32'd1);
    tick();
    chk("wait_start_low", 32'(md_start), 32'd0);
    chk("wait_stall", 32'(stall), 32'd1);
    tick(); tick(); tick();
    md_busy = 1'b0;
    #1;
    chk("wait_busy0_stall", 32'(stall), 32'd1);
    tick();
    chk("idle_after_busy", 32'(req_ready), 32'd1);
    req(1'b0, 4'd0, 32'd0, 32'd0);
    chk("idle_hold_a", md_a, 32'h0000_0003);

    // mthi then mflo, mfhi back to back
    req(1'b1, 4'd6, 32'h1234_5678, 32'd0);
    chk("mthi_ready", 32'(req_ready), 32'd1);
    tick();
    chk("mthi_start", 32'(md_start), 32'd1);
    chk("mthi_op", 32'(md_op), 32'd6);
    chk("mthi_a", md_a, 32'h1234_5678);
    md_lo = 32'hDEAD_BEEF;
    req(1'b1, 4'd9, 32'd0, 32'd0);
    chk("mthi_launch_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mthi_back_idle", 32'(req_ready), 32'd1);
    chk("mthi_start_low", 32'(md_start), 32'd0);
    tick();
    chk("mflo_valid", 32'(rd_valid), 32'd1);
    chk("mflo_data", rd_data, 32'hDEAD_BEEF);
    chk("mflo_no_start", 32'(md_start), 32'd0);
    md_hi = 32'hCAFE_F00D;
    req(1'b1, 4'd8, 32'd0, 32'd0);
    chk("mfhi_b2b_ready", 32'(req_ready), 32'd1);
    tick();
    chk("mfhi_b2b_valid", 32'(rd_valid), 32'd1);
    chk("mfhi_b2b_data", rd_data, 32'hCAFE_F00D);
    req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", rd_data, 32'hCAFE_F00D);

    // reserved opcode and busy-in-IDLE stalls
    req(1'b1, 4'd10, 32'd5, 32'd5);
    chk("rsvd_ready", 32'(req_ready), 32'd0);
    chk("rsvd_stall", 32'(stall), 32'd1);
    tick();
    chk("rsvd_no_start", 32'(md_start), 32'd0);
    md_busy = 1'b1;
    req(1'b1, 4'd8, 32'd0, 32'd0);
    chk("mfhi_busy_stall", 32'(stall), 32'd1);
    md_busy = 1'b0;

    // div followed by mfhi
    req(1'b1, 4'd2, 32'd100, 32'd7);
    tick();
    chk("div_start", 32'(md_start), 32'd1);
    chk("div_op", 32'(md_op), 32'd2);
    md_busy = 1'b1;
    md_hi = 32'h1111_1111;
    req(1'b1, 4'd8, 32'd0, 32'd0);
    chk("div_mfhi_stall_l", 32'(stall), 32'd1);
    tick();
    chk("div_mfhi_stall_w", 32'(stall), 32'd1);
    tick();
    md_busy = 1'b0;
    md_hi = 32'h0000_0002;
    #1;
    chk("div_mfhi_stall_w2", 32'(stall), 32'd1);
    tick();
    chk("div_mfhi_ready", 32'(req_ready), 32'd1);
    tick();
    chk("div_mfhi_valid", 32'(rd_valid), 32'd1);
    chk("div_mfhi_data", rd_data, 32'h0000_0002);
    req(1'b0, 4'd0, 32'd0, 32'd0);

    // watchdog: busy held 40 cycles
    req(1'b1, 4'd1, 32'hA5A5_A5A5, 32'd1);
    tick();
    md_busy = 1'b1;
    req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    repeat (15) tick();
    chk("wd_before", 32'(md_timeout), 32'd0);
    tick();
    chk("wd_set", 32'(md_timeout), 32'd1);
    repeat (22) tick();
    md_busy = 1'b0;
    tick();
    chk("wd_sticky", 32'(md_timeout), 32'd1);
    req(1'b1, 4'd9, 32'd0, 32'd0);
    chk("wd_back_idle", 32'(req_ready), 32'd1);
    req(1'b0, 4'd0, 32'd0, 32'd0);

    // reset during WAIT
    req(1'b1, 4'd3, 32'h0BAD_F00D, 32'd3);
    tick();
    md_busy = 1'b1;
    req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("pre_rst_a", md_a, 32'h0BAD_F00D);
    reset = 1'b1;
    #1;
    chk("rst_wait_a", md_a, 32'd0);
    chk("rst_wait_op", 32'(md_op), 32'd0);
    chk("rst_wait_timeout", 32'(md_timeout), 32'd0);
    md_busy = 1'b0;
    reset = 1'b0;
    tick();

    // reset during LAUNCH drops md_start at once
    req(1'b1, 4'd4, 32'd9, 32'd9);
    tick();
    chk("madd_start", 32'(md_start), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_launch_start", 32'(md_start), 32'd0);
    reset = 1'b0;
    req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // req_valid with flush in IDLE
    flush = 1'b1;
    req(1'b1, 4'd0, 32'd77, 32'd88);
    chk("flush_ready", 32'(req_ready), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_no_start", 32'(md_start), 32'd0);
    chk("flush_a_unchanged", md_a, 32'd0);
    flush = 1'b0;
    #1;
    chk("flush_still_idle", 32'(req_ready), 32'd1);
    req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
